// File: rtl/spiking_neuron_array.sv
// Bank of independent integrate-and-fire neurons with saturating leak, programmable
// threshold, divider/LIF residue handling, refractory period and saturating spike counters.
module spiking_neuron_array #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int REFRAC_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS*WIDTH-1:0] w,
    input  logic [WIDTH-1:0]          threshold,
    input  logic [WIDTH-1:0]          leak,
    input  logic [REFRAC_W-1:0]       refrac,
    input  logic                      mode,
    input  logic                      cnt_clr,
    output logic [CHANNELS-1:0]       spike,
    output logic [CHANNELS*CNT_W-1:0] spike_count,
    output logic [CHANNELS*WIDTH-1:0] v_out
);

    localparam logic [REFRAC_W-1:0] R_ONE = REFRAC_W'(1);
    localparam logic [CNT_W-1:0]    C_ONE = CNT_W'(1);

    // Threshold of 0 stands for 2^WIDTH, so compare everything in WIDTH+1 bits.
    logic [WIDTH:0] thr_ext;
    logic [WIDTH:0] leak_ext;

    always_comb begin
        leak_ext = {1'b0, leak};
        thr_ext  = (threshold == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, threshold};
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0]    v_q, v_d;
        logic [REFRAC_W-1:0] r_q, r_d;
        logic [CNT_W-1:0]    cnt_q;
        logic                spike_q;
        logic                fire;
        logic [WIDTH:0]      sum, leaked, residue;

        always_comb begin
            sum     = {1'b0, v_q} + {1'b0, w[i*WIDTH +: WIDTH]};
            leaked  = (sum >= leak_ext) ? (sum - leak_ext) : '0;
            residue = leaked - thr_ext;
            v_d     = v_q;
            r_d     = r_q;
            fire    = 1'b0;
            if (en) begin
                if (r_q != '0) begin
                    // Refractory: the incoming weight is dropped, membrane frozen.
                    r_d = r_q - R_ONE;
                end else if (leaked >= thr_ext) begin
                    fire = 1'b1;
                    r_d  = refrac;
                    if (mode)
                        v_d = '0;
                    else if (residue[WIDTH])
                        v_d = '1;
                    else
                        v_d = residue[WIDTH-1:0];
                end else begin
                    v_d = leaked[WIDTH-1:0];
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q     <= '0;
                r_q     <= '0;
                spike_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                v_q     <= v_d;
                r_q     <= r_d;
                spike_q <= fire;
                // Clear has priority over a coincident spike.
                if (cnt_clr)
                    cnt_q <= '0;
                else if (fire && (cnt_q != '1))
                    cnt_q <= cnt_q + C_ONE;
            end
        end

        assign spike[i]                        = spike_q;
        assign v_out[i*WIDTH +: WIDTH]         = v_q;
        assign spike_count[i*CNT_W +: CNT_W]   = cnt_q;
    end

endmodule

// File: tb/tb_spiking_neuron_array.sv
// Scoreboard bench for spiking_neuron_array: driver pushes expected outputs per tick,
// a negedge monitor pops and compares; directed hand-computed checks cover the key scenarios.
module tb_spiking_neuron_array;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int RW = 4;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              mode = 1'b0;
    logic              cnt_clr = 1'b0;
    logic [CH*W-1:0]   w = '0;
    logic [W-1:0]      threshold = '0;
    logic [W-1:0]      leak = '0;
    logic [RW-1:0]     refrac = '0;
    logic [CH-1:0]     spike;
    logic [CH*CW-1:0]  spike_count;
    logic [CH*W-1:0]   v_out;

    spiking_neuron_array #(.CHANNELS(CH), .WIDTH(W), .REFRAC_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .w(w), .threshold(threshold), .leak(leak),
        .refrac(refrac), .mode(mode), .cnt_clr(cnt_clr), .spike(spike),
        .spike_count(spike_count), .v_out(v_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               due;
        logic [CH-1:0]    s;
        logic [CH*W-1:0]  v;
        logic [CH*CW-1:0] c;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_x;
    int checks = 0;
    int failures = 0;
    int mv[CH];
    int mr[CH];
    int mc[CH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the registered outputs against the entry due on this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_x = exp_q.pop_front();
            checks += 3;
            if (spike !== mon_x.s) begin
                failures++;
                $display("FAIL sb_spike cyc=%0d: got=%b expected=%b", cyc, spike, mon_x.s);
            end
            if (v_out !== mon_x.v) begin
                failures++;
                $display("FAIL sb_v cyc=%0d: got=%h expected=%h", cyc, v_out, mon_x.v);
            end
            if (spike_count !== mon_x.c) begin
                failures++;
                $display("FAIL sb_count cyc=%0d: got=%h expected=%h", cyc, spike_count, mon_x.c);
            end
        end
    end

    // Drives one clock edge with the given enable/clear, advances the model, queues the result.
    task automatic tick(input bit e, input bit clr);
        exp_t x;
        int s, l, t;
        bit fired;
        @(negedge clk);
        #1;
        en = e;
        cnt_clr = clr;
        x.due = cyc + 1;
        x.s = '0;
        x.v = '0;
        x.c = '0;
        for (int ch = 0; ch < CH; ch++) begin
            fired = 1'b0;
            if (e) begin
                if (mr[ch] > 0) begin
                    mr[ch] = mr[ch] - 1;
                end else begin
                    s = mv[ch] + int'(w[ch*W +: W]);
                    l = (s >= int'(leak)) ? s - int'(leak) : 0;
                    t = (threshold == 0) ? 256 : int'(threshold);
                    if (l >= t) begin
                        fired = 1'b1;
                        mr[ch] = int'(refrac);
                        mv[ch] = mode ? 0 : ((l - t > 255) ? 255 : l - t);
                    end else begin
                        mv[ch] = l;
                    end
                end
            end
            if (clr) mc[ch] = 0;
            else if (fired && mc[ch] < 65535) mc[ch] = mc[ch] + 1;
            x.s[ch] = fired;
            x.v[ch*W +: W] = mv[ch][W-1:0];
            x.c[ch*CW +: CW] = mc[ch][CW-1:0];
        end
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        en = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int ch = 0; ch < CH; ch++) begin
            mv[ch] = 0;
            mr[ch] = 0;
            mc[ch] = 0;
        end
        #1;
        chk("async_rst_spike", spike, 0);
        chk("async_rst_v", v_out, 0);
        chk("async_rst_count", spike_count, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    int lif_v[12] = '{30, 60, 90, 0, 0, 0, 30, 60, 90, 0, 0, 0};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_spike", spike, 0);
        chk("reset_v", v_out, 0);
        chk("reset_count", spike_count, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;

        // Divider mode, w0=64: a spike every fourth tick.
        w = {8'd255, 8'd7, 8'd100, 8'd64};
        threshold = 8'd0; leak = 8'd0; refrac = 4'd0; mode = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            tick(1'b1, 1'b0);
            chk("div64_spike", spike[0], (t % 4 == 0) ? 1 : 0);
        end
        chk("div64_count", spike_count[CW-1:0], 4);
        chk("div64_v", v_out[W-1:0], 0);

        // Divider mode, w0=255: 255 spikes over 256 ticks, none on the first.
        tick(1'b0, 1'b1);
        chk("clr_idle_count", spike_count[CW-1:0], 0);
        w[W-1:0] = 8'd255;
        for (int t = 1; t <= 256; t++) begin
            tick(1'b1, 1'b0);
            if (t == 1) chk("div255_first", spike[0], 0);
        end
        chk("div255_count", spike_count[CW-1:0], 255);
        chk("div255_v", v_out[W-1:0], 0);

        // LIF with refractory 2; en held low for 10 cycles inside the refractory window.
        threshold = 8'd100; leak = 8'd10; refrac = 4'd2; mode = 1'b1;
        w[W-1:0] = 8'd40;
        tick(1'b0, 1'b1);
        for (int t = 1; t <= 12; t++) begin
            tick(1'b1, (t == 10));
            chk("lif_v", v_out[W-1:0], lif_v[t-1]);
            chk("lif_spike", spike[0], (t == 4 || t == 10) ? 1 : 0);
            if (t == 10) chk("clr_on_spike", spike_count[CW-1:0], 0);
            if (t == 5) begin
                for (int k = 0; k < 10; k++) begin
                    w[W-1:0] = 8'd200;
                    tick(1'b0, 1'b0);
                    chk("idle_spike", spike[0], 0);
                end
                w[W-1:0] = 8'd40;
                chk("idle_v", v_out[W-1:0], 0);
                chk("idle_count", spike_count[CW-1:0], 1);
            end
        end

        // Leak floor: weight smaller than leak never builds up.
        w[W-1:0] = 8'd5;
        refrac = 4'd0;
        for (int t = 1; t <= 20; t++) begin
            tick(1'b1, 1'b0);
            chk("floor_v", v_out[W-1:0], 0);
            chk("floor_spike", spike[0], 0);
        end

        // Residue saturation in divider mode with threshold 1.
        mode = 1'b0; threshold = 8'd1; leak = 8'd0; w[W-1:0] = 8'd255;
        for (int t = 1; t <= 3; t++) begin
            tick(1'b1, 1'b0);
            chk("sat_v", v_out[W-1:0], (t == 1) ? 254 : 255);
            chk("sat_spike", spike[0], 1);
        end

        // Reset while refractory, then a fresh LIF run must match the first timing.
        threshold = 8'd100; leak = 8'd10; refrac = 4'd2; mode = 1'b1; w[W-1:0] = 8'd40;
        tick(1'b1, 1'b0);
        chk("pre_rst_spike", spike[0], 1);
        do_reset();
        for (int t = 1; t <= 6; t++) begin
            tick(1'b1, 1'b0);
            chk("post_rst_v", v_out[W-1:0], lif_v[t-1]);
            chk("post_rst_spike", spike[0], (t == 4) ? 1 : 0);
        end

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spiking_neuron_array.md
# spiking_neuron_array

Parametrised bank of independent integrate-and-fire neurons. Each neuron accumulates a per-channel weight every enabled tick, applies a saturating leak, fires on crossing a programmable threshold, and then either keeps the residue (divider mode) or resets (LIF mode), with an optional refractory period. It is the multi-channel, configurable successor to the single-channel overflow divider neuron. It feeds spike trains and per-channel spike counts to the JTAG-readable status logic.

## Interface
- CHANNELS, 4, number of neurons
- WIDTH, 8, membrane/weight/threshold/leak width
- REFRAC_W, 4, refractory counter width
- CNT_W, 16, per-channel spike counter width

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  tick enable; state advances only when 1
- w  in  CHANNELS*WIDTH  per-channel weight, channel i at [i*WIDTH +: WIDTH]
- threshold  in  WIDTH  firing threshold shared by all channels; 0 means 2^WIDTH
- leak  in  WIDTH  amount subtracted each tick after integration
- refrac  in  REFRAC_W  refractory ticks after each spike
- mode  in  1  0 = divider (residue kept), 1 = LIF (reset to 0)
- cnt_clr  in  1  synchronous clear of all spike counters
- spike  out  CHANNELS  registered one-clock spike pulse per channel
- spike_count  out  CHANNELS*CNT_W  saturating spike count per channel, channel i at [i*CNT_W +: CNT_W]
- v_out  out  CHANNELS*WIDTH  membrane potential per channel

## Operation
- Reset (rst=0, any time, including mid-operation): v=0, refractory counter r=0, spike=0, spike_count=0. All state is cleared immediately.
- en=0: v, r and the counters hold; spike<=0. cnt_clr is still honoured.
- en=1, per channel, evaluated at each rising edge:
  - If r>0: r<=r-1, v holds, spike<=0. The weight is discarded.
  - Otherwise:
    - s = v + w, computed in WIDTH+1 bits.
    - l = s - leak if s>=leak, else 0.
    - T = threshold, or 2^WIDTH when threshold==0. T is compared in WIDTH+1 bits.
    - If l>=T: spike<=1, r<=refrac.
      - mode 0: v<=min(l-T, 2^WIDTH-1).
      - mode 1: v<=0.
    - Else: spike<=0, v<=l. This always fits in WIDTH bits.
- threshold, leak, refrac and mode are sampled every tick. Changing them mid-run takes effect on the next enabled edge and does not disturb v or r.
- With threshold=0, leak=0, refrac=0 and mode=0, the spike rate is exactly w/2^WIDTH, matching the legacy divider.
- spike_count: increments by 1 on each edge where spike is set to 1, and saturates at 2^CNT_W-1.
- cnt_clr=1 forces all counters to 0. When it coincides with a spike, clear wins and the result is 0.
- The spike output is a clean registered pulse. It is never gated with clk.

## Timing
- Spike latency: the spike is high for exactly the one clock following the enabled edge on which the crossing was computed.
- v_out, spike_count and spike all update on the same edge.
- Back-to-back spikes on consecutive ticks are legal when refrac=0, for example large w with small T.
- With refrac=R, the minimum spike spacing is R+1 enabled ticks.
- Channels are fully independent; all outputs update on the same edge.
- Reset release is synchronous to the next rising edge.

## Test plan
- Divider mode, WIDTH=8, th=0, leak=0, refrac=0, w0=64, 16 ticks: spike on ticks 4, 8, 12 and 16; spike_count0=4; v0=0 at the end.
- w0=255, same configuration, 256 ticks: no spike on tick 1; spike_count0=255; v0=0 at the end.
- LIF mode, th=100, leak=10, w=40, refrac=2:
  - v0 runs 30, 60, 90, then spikes on tick 4 with v0=0.
  - Ticks 5 and 6 are refractory with no spike.
  - Tick 7 gives v0=30; the spike period is 6 ticks.
- Leak floor: w=5, leak=10, th=100: v stays 0 and no spike occurs over 20 ticks. Residue saturation: mode 0, th=1, w=255 gives v=254 then 255 (saturated), with a spike on every tick.
- en=0 for 10 cycles mid-run: v, r and spike_count are unchanged and spike=0. cnt_clr on a spiking edge: count reads 0.
- Assert rst mid-run while a channel is in its refractory period: all outputs are 0 immediately. After release, the first spike timing matches a fresh start.
